// File: rtl/uart_seg7_unit.sv
// uart_seg7_unit: 8N1 UART receiver and transmitter plus a dual
// hex-digit 7-segment decoder for board-level serial/display glue.

module uart_seg7_tx #(
    parameter int BitCycles = 96
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       ser,
    output logic       busy
);
    localparam int CntW = $clog2(BitCycles + 1);

    typedef enum logic [1:0] {
        TxIdle,
        TxStart,
        TxData,
        TxStop
    } tx_state_t;

    tx_state_t       state;
    tx_state_t       state_n;
    logic [CntW-1:0] cnt;
    logic [CntW-1:0] cnt_n;
    logic [2:0]      idx;
    logic [2:0]      idx_n;
    logic [7:0]      shreg;
    logic [7:0]      shreg_n;
    logic            ser_n;
    logic            busy_n;
    logic            bit_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= TxIdle;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            ser   <= 1'b1;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
            ser   <= ser_n;
            busy  <= busy_n;
        end
    end

    // Line and busy are registered from the next state so both change together.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        ser_n   = ser;
        busy_n  = busy;
        bit_end = (cnt == CntW'(BitCycles - 1));
        if (state != TxIdle) begin
            cnt_n = bit_end ? '0 : cnt + 1'b1;
        end
        case (state)
            TxIdle: begin
                if (start) begin
                    state_n = TxStart;
                    shreg_n = data;
                    cnt_n   = '0;
                    ser_n   = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            TxStart: begin
                if (bit_end) begin
                    state_n = TxData;
                    idx_n   = '0;
                    ser_n   = shreg[0];
                end
            end
            TxData: begin
                if (bit_end) begin
                    if (idx == 3'd7) begin
                        state_n = TxStop;
                        ser_n   = 1'b1;
                    end else begin
                        idx_n   = idx + 1'b1;
                        shreg_n = {1'b0, shreg[7:1]};
                        ser_n   = shreg[1];
                    end
                end
            end
            TxStop: begin
                if (bit_end) begin
                    if (start) begin
                        state_n = TxStart;
                        shreg_n = data;
                        ser_n   = 1'b0;
                    end else begin
                        state_n = TxIdle;
                        busy_n  = 1'b0;
                    end
                end
            end
            default: state_n = TxIdle;
        endcase
    end
endmodule

module uart_seg7_rx #(
    parameter int BitCycles  = 96,
    parameter int HalfCycles = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       ready,
    output logic       frame_err
);
    localparam int CntW = $clog2(BitCycles + 1);

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop,
        RxWait
    } rx_state_t;

    rx_state_t       state;
    rx_state_t       state_n;
    logic            meta;
    logic            samp;
    logic [CntW-1:0] cnt;
    logic [CntW-1:0] cnt_n;
    logic [2:0]      idx;
    logic [2:0]      idx_n;
    logic [7:0]      shreg;
    logic [7:0]      shreg_n;
    logic [7:0]      data_n;
    logic            ready_n;
    logic            err_n;
    logic            bit_end;
    logic            half_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            samp <= 1'b1;
        end else begin
            meta <= rxd;
            samp <= meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RxIdle;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            data      <= '0;
            ready     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shreg     <= shreg_n;
            data      <= data_n;
            ready     <= ready_n;
            frame_err <= err_n;
        end
    end

    // Bit timing counts raw clocks from the start edge, so no drift accumulates.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        shreg_n  = shreg;
        data_n   = data;
        ready_n  = 1'b0;
        err_n    = 1'b0;
        bit_end  = (cnt == CntW'(BitCycles - 1));
        half_end = (cnt == CntW'(HalfCycles - 1));
        if (state == RxStart || state == RxData || state == RxStop) begin
            cnt_n = cnt + 1'b1;
        end
        case (state)
            RxIdle: begin
                if (!samp) begin
                    state_n = RxStart;
                    cnt_n   = '0;
                end
            end
            RxStart: begin
                if (half_end) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = samp ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    shreg_n = {samp, shreg[7:1]};
                    if (idx == 3'd7) begin
                        state_n = RxStop;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            RxStop: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (samp) begin
                        ready_n = 1'b1;
                        data_n  = shreg;
                        state_n = RxIdle;
                    end else begin
                        err_n   = 1'b1;
                        state_n = RxWait;
                    end
                end
            end
            RxWait: begin
                if (samp) begin
                    state_n = RxIdle;
                end
            end
            default: state_n = RxIdle;
        endcase
    end
endmodule

module uart_seg7_hex (
    input  logic [3:0] nib,
    output logic [7:0] seg
);
    // Segment order is {dp,g,f,e,d,c,b,a}; dp stays dark.
    always_comb begin
        seg = 8'h00;
        unique case (nib)
            4'h0: seg = 8'h3F;
            4'h1: seg = 8'h06;
            4'h2: seg = 8'h5B;
            4'h3: seg = 8'h4F;
            4'h4: seg = 8'h66;
            4'h5: seg = 8'h6D;
            4'h6: seg = 8'h7D;
            4'h7: seg = 8'h07;
            4'h8: seg = 8'h7F;
            4'h9: seg = 8'h6F;
            4'hA: seg = 8'h77;
            4'hB: seg = 8'h7C;
            4'hC: seg = 8'h39;
            4'hD: seg = 8'h5E;
            4'hE: seg = 8'h79;
            4'hF: seg = 8'h71;
        endcase
    end
endmodule

module uart_seg7_unit #(
    parameter int ClkFrequency = 11059200,
    parameter int Baud         = 115200,
    parameter int Oversampling = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       rxd_data_ready,
    output logic [7:0] rxd_data,
    output logic       rx_frame_err,
    output logic       txd,
    input  logic       txd_start,
    input  logic [7:0] txd_data,
    output logic       txd_busy,
    input  logic [7:0] disp_value,
    output logic [7:0] seg_lo,
    output logic [7:0] seg_hi
);
    localparam int BitCycles  = (ClkFrequency + Baud / 2) / Baud;
    localparam int TickCycles = BitCycles / Oversampling;
    // Mid-bit sample lands on the oversampling tick grid.
    localparam int HalfCycles = TickCycles * (Oversampling / 2);

    uart_seg7_rx #(
        .BitCycles (BitCycles),
        .HalfCycles(HalfCycles)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .data     (rxd_data),
        .ready    (rxd_data_ready),
        .frame_err(rx_frame_err)
    );

    uart_seg7_tx #(
        .BitCycles(BitCycles)
    ) u_tx (
        .clk  (clk),
        .rst  (rst),
        .start(txd_start),
        .data (txd_data),
        .ser  (txd),
        .busy (txd_busy)
    );

    uart_seg7_hex u_hex_lo (
        .nib(disp_value[3:0]),
        .seg(seg_lo)
    );

    uart_seg7_hex u_hex_hi (
        .nib(disp_value[7:4]),
        .seg(seg_hi)
    );
endmodule

// File: tb/tb_uart_seg7_unit.sv
// Directed bench for uart_seg7_unit: TX framing, RX framing and errors,
// loopback and the 7-segment table.

module tb_uart_seg7_unit;
    localparam int N = 96;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd_drv = 1'b1;
    logic       loop = 1'b0;
    logic       rxd_w;
    logic       rxd_data_ready;
    logic [7:0] rxd_data;
    logic       rx_frame_err;
    logic       txd;
    logic       txd_start = 1'b0;
    logic [7:0] txd_data = 8'h00;
    logic       txd_busy;
    logic [7:0] disp_value = 8'h00;
    logic [7:0] seg_lo;
    logic [7:0] seg_hi;

    int checks = 0;
    int failures = 0;
    int rdy_cnt = 0;
    int err_cnt = 0;
    logic [7:0] rx_q[$];

    logic [7:0] seg_tab [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    assign rxd_w = loop ? txd : rxd_drv;

    always #5 clk = ~clk;

    uart_seg7_unit dut (
        .clk           (clk),
        .rst           (rst),
        .rxd           (rxd_w),
        .rxd_data_ready(rxd_data_ready),
        .rxd_data      (rxd_data),
        .rx_frame_err  (rx_frame_err),
        .txd           (txd),
        .txd_start     (txd_start),
        .txd_data      (txd_data),
        .txd_busy      (txd_busy),
        .disp_value    (disp_value),
        .seg_lo        (seg_lo),
        .seg_hi        (seg_hi)
    );

    always @(negedge clk) begin
        if (rxd_data_ready) begin
            rdy_cnt++;
            rx_q.push_back(rxd_data);
        end
        if (rx_frame_err) begin
            err_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic uart_send(input logic [7:0] b, input logic stop);
        rxd_drv = 1'b0;
        cycles(N);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            cycles(N);
        end
        rxd_drv = stop;
        cycles(N);
        rxd_drv = 1'b1;
    endtask

    initial begin
        logic [9:0] frame;
        logic [7:0] v;
        int r0;
        int e0;
        int low_cnt;

        cycles(3);
        check("rst_txd", txd, 1);
        check("rst_busy", txd_busy, 0);
        check("rst_ready", rxd_data_ready, 0);
        check("rst_err", rx_frame_err, 0);
        check("rst_data", rxd_data, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        cycles(5);

        // TX 0x55 with an ignored mid-frame request for 0xAA
        frame = {1'b1, 8'h55, 1'b0};
        @(negedge clk);
        txd_data  = 8'h55;
        txd_start = 1'b1;
        @(posedge clk);
        #1;
        txd_start = 1'b0;
        check("tx_busy_rise", txd_busy, 1);
        check("tx_start_low", txd, 0);
        for (int b = 0; b < 10; b++) begin
            repeat (N / 2) @(posedge clk);
            #1;
            check($sformatf("tx_bit%0d", b), txd, frame[b]);
            if (b == 3) begin
                txd_data  = 8'hAA;
                txd_start = 1'b1;
                @(posedge clk);
                #1;
                txd_start = 1'b0;
                repeat (N / 2 - 2) @(posedge clk);
            end else begin
                repeat (N / 2 - 1) @(posedge clk);
            end
            #1;
            check($sformatf("tx_busy_b%0d", b), txd_busy, 1);
            @(posedge clk);
            #1;
        end
        check("tx_busy_fall", txd_busy, 0);
        check("tx_idle_line", txd, 1);
        cycles(200);
        check("tx_no_queue_busy", txd_busy, 0);
        check("tx_no_queue_txd", txd, 1);

        // reset in the middle of a frame
        @(negedge clk);
        txd_data  = 8'h0F;
        txd_start = 1'b1;
        @(posedge clk);
        #1;
        txd_start = 1'b0;
        cycles(300);
        check("mid_busy_pre", txd_busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_txd", txd, 1);
        check("mid_rst_busy", txd_busy, 0);
        cycles(2);
        @(negedge clk);
        rst = 1'b0;
        low_cnt = 0;
        for (int i = 0; i < 1200; i++) begin
            cycles(1);
            if (txd !== 1'b1 || txd_busy !== 1'b0) low_cnt++;
        end
        check("post_rst_quiet", low_cnt, 0);

        // RX 0xA5
        r0 = rdy_cnt;
        e0 = err_cnt;
        uart_send(8'hA5, 1'b1);
        cycles(20);
        check("rx_ready_cnt", rdy_cnt - r0, 1);
        check("rx_err_none", err_cnt - e0, 0);
        check("rx_data", rxd_data, 8'hA5);
        cycles(200);
        check("rx_data_hold", rxd_data, 8'hA5);

        // 20-cycle glitch
        r0 = rdy_cnt;
        e0 = err_cnt;
        rxd_drv = 1'b0;
        cycles(20);
        rxd_drv = 1'b1;
        cycles(200);
        check("glitch_ready", rdy_cnt - r0, 0);
        check("glitch_err", err_cnt - e0, 0);

        // bad stop bit
        r0 = rdy_cnt;
        e0 = err_cnt;
        uart_send(8'h3C, 1'b0);
        cycles(200);
        check("ferr_pulse", err_cnt - e0, 1);
        check("ferr_ready", rdy_cnt - r0, 0);
        check("ferr_data", rxd_data, 8'hA5);

        // loopback, three frames back to back
        loop = 1'b1;
        rx_q.delete();
        r0 = rdy_cnt;
        cycles(10);
        @(negedge clk);
        txd_data  = 8'h00;
        txd_start = 1'b1;
        @(posedge clk);
        #1;
        txd_data = 8'hFF;
        cycles(10 * N);
        txd_data = 8'h3C;
        check("lb_gap_busy", txd_busy, 1);
        check("lb_gap_start", txd, 0);
        cycles(10 * N);
        txd_start = 1'b0;
        cycles(10 * N + 100);
        check("lb_ready_cnt", rdy_cnt - r0, 3);
        check("lb_qsize", rx_q.size(), 3);
        if (rx_q.size() == 3) begin
            check("lb_byte0", rx_q[0], 8'h00);
            check("lb_byte1", rx_q[1], 8'hFF);
            check("lb_byte2", rx_q[2], 8'h3C);
        end
        check("lb_busy_end", txd_busy, 0);
        loop = 1'b0;

        // segment decoder sweep
        for (int i = 0; i < 256; i++) begin
            v = 8'(i);
            disp_value = v;
            #1;
            check($sformatf("seg_lo_%02h", v), seg_lo, seg_tab[v[3:0]]);
            check($sformatf("seg_hi_%02h", v), seg_hi, seg_tab[v[7:4]]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
